// File: rtl/ddr3_writer_pkg.sv
// Shared constants and state encodings for the DDR3 pixel writer.
package ddr3_writer_pkg;

  localparam int unsigned PIX_PER_WORD   = 16;
  localparam int unsigned BYTES_PER_WORD = 16;

  typedef enum logic [2:0] {
    FIdle,
    FActive,
    FFlush,
    FDrain,
    FDone
  } frame_state_t;

  typedef enum logic [1:0] {
    WIdle,
    WIssue,
    WWait
  } wr_state_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO with first-word fall-through; holds packed words
// between the pixel packer and the DDR write handshake.
module word_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still honoured.
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ddr3_pixel_writer.sv
// Packs an 8-bit pixel stream into 128-bit words and writes them to DDR3
// through the wr_en / write_complete handshake at linearly increasing addresses.
module ddr3_pixel_writer
  import ddr3_writer_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned WORD_W     = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [CNT_W-1:0]  frame_pixels,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [WORD_W-1:0] write_data_input,
  input  logic              write_complete,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned PackCntW  = $clog2(PIX_PER_WORD);
  localparam int unsigned ByteShift = $clog2(BYTES_PER_WORD);
  localparam logic [PackCntW-1:0] LastSlot = PackCntW'(PIX_PER_WORD - 1);

  frame_state_t         frame_state_q, frame_state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [CNT_W-1:0]     pix_left_q, pix_left_d;
  logic [CNT_W-1:0]     words_left_q, words_left_d;
  logic [WORD_W-1:0]    pack_q, pack_d;
  logic [PackCntW-1:0]  pack_cnt_q, pack_cnt_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  wr_state_t            wr_state_q, wr_state_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    word_idx_q, word_idx_d;
  logic [WORD_W-1:0]    data_q, data_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0]    fifo_din, fifo_dout;
  logic                 start_accept, pix_accept;
  logic [CNT_W:0]       words_calc;

  assign start_accept = start && (frame_state_q == FIdle);
  // ceil(frame_pixels / 16), computed one bit wider so the +15 cannot overflow.
  assign words_calc   = ({1'b0, frame_pixels} + (CNT_W + 1)'(PIX_PER_WORD - 1)) >> PackCntW;

  // Hold off the 16th pixel when its word would have nowhere to go.
  assign pix_ready  = (frame_state_q == FActive) && (pix_left_q != '0) &&
                      !(fifo_full && (pack_cnt_q == LastSlot));
  assign pix_accept = pix_valid && pix_ready;

  assign wr_en            = wr_en_q;
  assign sdram_address    = addr_q;
  assign write_data_input = data_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame FSM and packer next-state.
  always_comb begin
    frame_state_d = frame_state_q;
    base_d        = base_q;
    pix_left_d    = pix_left_q;
    words_left_d  = words_left_q;
    pack_d        = pack_q;
    pack_cnt_d    = pack_cnt_q;
    fifo_push     = 1'b0;
    fifo_din      = pack_q;

    if (fifo_pop) begin
      words_left_d = words_left_q - 1'b1;
    end

    unique case (frame_state_q)
      FIdle: begin
        if (start) begin
          base_d        = frame_base;
          pix_left_d    = frame_pixels;
          words_left_d  = words_calc[CNT_W-1:0];
          pack_d        = '0;
          pack_cnt_d    = '0;
          frame_state_d = (frame_pixels == '0) ? FDone : FActive;
        end
      end
      FActive: begin
        if (pix_accept) begin
          pack_d[pack_cnt_q*PIX_W +: PIX_W] = pix_data;
          pix_left_d = pix_left_q - 1'b1;
          if (pack_cnt_q == LastSlot) begin
            fifo_push  = 1'b1;
            fifo_din   = pack_d;
            pack_d     = '0;
            pack_cnt_d = '0;
          end else begin
            pack_cnt_d = pack_cnt_q + 1'b1;
          end
          if (pix_left_q == CNT_W'(1)) begin
            frame_state_d = (pack_cnt_q == LastSlot) ? FDrain : FFlush;
          end
        end
      end
      FFlush: begin
        // Unused bytes are already zero because the packer clears after every word.
        if (!fifo_full) begin
          fifo_push     = 1'b1;
          fifo_din      = pack_q;
          pack_d        = '0;
          pack_cnt_d    = '0;
          frame_state_d = FDrain;
        end
      end
      FDrain: begin
        if (words_left_q == '0) begin
          frame_state_d = FDone;
        end
      end
      FDone: begin
        frame_state_d = FIdle;
      end
      default: begin
        frame_state_d = FIdle;
      end
    endcase

    frame_done_d = (frame_state_q == FDone);
    // Stays high through the frame_done cycle and drops the cycle after.
    busy_d       = (frame_state_d != FIdle) || (frame_state_q == FDone);
  end

  // Write FSM next-state: one wr_en pulse per word, then wait for completion.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    word_idx_d = word_idx_q;
    fifo_pop   = 1'b0;

    if (start_accept) begin
      word_idx_d = '0;
    end

    unique case (wr_state_q)
      WIdle: begin
        if (!fifo_empty) begin
          wr_state_d = WIssue;
          wr_en_d    = 1'b1;
          addr_d     = base_q + (word_idx_q << ByteShift);
          data_d     = fifo_dout;
        end
      end
      WIssue: begin
        wr_state_d = WWait;
      end
      WWait: begin
        if (write_complete) begin
          fifo_pop   = 1'b1;
          word_idx_d = word_idx_q + 1'b1;
          wr_state_d = WIdle;
        end
      end
      default: begin
        wr_state_d = WIdle;
      end
    endcase
  end

  // Frame FSM and packer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_state_q <= FIdle;
      base_q        <= '0;
      pix_left_q    <= '0;
      words_left_q  <= '0;
      pack_q        <= '0;
      pack_cnt_q    <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_state_q <= frame_state_d;
      base_q        <= base_d;
      pix_left_q    <= pix_left_d;
      words_left_q  <= words_left_d;
      pack_q        <= pack_d;
      pack_cnt_q    <= pack_cnt_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Write FSM, address counter and registered DDR-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= WIdle;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      word_idx_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      word_idx_q <= word_idx_d;
    end
  end

endmodule

// File: tb/tb_ddr3_pixel_writer.sv
// Directed bench for ddr3_pixel_writer with a DDR-side responder that
// returns write_complete two cycles after each wr_en and logs every write.
module tb_ddr3_pixel_writer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  frame_base;
  logic [23:0]  frame_pixels;
  logic         pix_valid;
  logic [7:0]   pix_data;
  logic         pix_ready;
  logic         wr_en;
  logic [31:0]  sdram_address;
  logic [127:0] write_data_input;
  logic         write_complete = 1'b0;
  logic         busy;
  logic         frame_done;

  int n_vec = 0;
  int n_err = 0;

  int           cyc = 0;
  logic         hold = 1'b0;
  logic         pend = 1'b0;
  logic         wr_en_prev = 1'b0;
  int           cnt_down = 0;
  int           dup_cnt = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           cmp_cyc = 0;
  int           pix_sent = 0;
  int           acc15_cyc = 0;
  logic [31:0]  addr_log[$];
  logic [127:0] data_log[$];
  int           wr_cyc_log[$];

  ddr3_pixel_writer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .frame_base       (frame_base),
    .frame_pixels     (frame_pixels),
    .pix_valid        (pix_valid),
    .pix_data         (pix_data),
    .pix_ready        (pix_ready),
    .wr_en            (wr_en),
    .sdram_address    (sdram_address),
    .write_data_input (write_data_input),
    .write_complete   (write_complete),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DDR interface model: logs writes, flags duplicates, acknowledges after 2 cycles.
  always @(posedge clk) begin
    #1;
    write_complete = 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (wr_en) begin
        if (pend || wr_en_prev) dup_cnt++;
        addr_log.push_back(sdram_address);
        data_log.push_back(write_data_input);
        wr_cyc_log.push_back(cyc);
        pend     = 1'b1;
        cnt_down = 2;
      end else if (pend && !hold) begin
        if (cnt_down <= 1) begin
          write_complete = 1'b1;
          pend           = 1'b0;
          cmp_cyc        = cyc;
        end else begin
          cnt_down--;
        end
      end
    end
    wr_en_prev = wr_en;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    wr_cyc_log.delete();
    dup_cnt  = 0;
    done_cnt = 0;
    pix_sent = 0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [23:0] npix);
    frame_base   = base;
    frame_pixels = npix;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Offers pixels v0+i until n_total have been accepted or the budget runs out.
  task automatic feed(input int n_total, input logic [7:0] v0, input int budget);
    int spent;
    spent = 0;
    while (pix_sent < n_total && spent < budget) begin
      logic rdy;
      pix_valid = 1'b1;
      pix_data  = v0 + 8'(pix_sent);
      rdy       = pix_ready;
      if (rdy && pix_sent == 15) acc15_cyc = cyc;
      tick();
      spent++;
      if (rdy) pix_sent++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_vec++;
    if ({pix_ready, wr_en, busy, frame_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000", {pix_ready, wr_en, busy, frame_done});
    end
    n_vec++;
    if (sdram_address !== 32'h0 || write_data_input !== 128'h0) begin
      n_err++;
      $display("FAIL reset_data: got addr %h data %h want 0", sdram_address, write_data_input);
    end
  endtask

  task automatic test_full_frame();
    clear_logs();
    pulse_start(32'h0000_1000, 24'd32);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL full_busy: got %b want 1", busy);
    end
    feed(32, 8'h00, 200);
    wait_done(200);
    n_vec++;
    if (addr_log.size() !== 2) begin
      n_err++;
      $display("FAIL full_count: got %0d writes want 2", addr_log.size());
    end else begin
      n_vec++;
      if (addr_log[0] !== 32'h1000 || data_log[0] !== 128'h0F0E0D0C0B0A09080706050403020100) begin
        n_err++;
        $display("FAIL full_word0: got %h %h", addr_log[0], data_log[0]);
      end
      n_vec++;
      if (addr_log[1] !== 32'h1010 || data_log[1] !== 128'h1F1E1D1C1B1A19181716151413121110) begin
        n_err++;
        $display("FAIL full_word1: got %h %h", addr_log[1], data_log[1]);
      end
      n_vec++;
      if (wr_cyc_log[0] !== acc15_cyc + 2) begin
        n_err++;
        $display("FAIL full_latency: got cycle %0d want %0d", wr_cyc_log[0], acc15_cyc + 2);
      end
    end
    n_vec++;
    if (done_cnt !== 1 || done_cyc <= cmp_cyc) begin
      n_err++;
      $display("FAIL full_done: got %0d pulses at %0d (last complete %0d) want 1 after",
               done_cnt, done_cyc, cmp_cyc);
    end
    n_vec++;
    if (dup_cnt !== 0) begin
      n_err++;
      $display("FAIL full_dup: got %0d duplicate wr_en want 0", dup_cnt);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_partial();
    clear_logs();
    pulse_start(32'h0000_1000, 24'd20);
    feed(20, 8'hA0, 200);
    wait_done(200);
    n_vec++;
    if (addr_log.size() !== 2) begin
      n_err++;
      $display("FAIL part_count: got %0d writes want 2", addr_log.size());
    end else begin
      n_vec++;
      if (data_log[0] !== 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0) begin
        n_err++;
        $display("FAIL part_word0: got %h", data_log[0]);
      end
      n_vec++;
      if (addr_log[1] !== 32'h1010 || data_log[1] !== 128'h0000_0000_0000_0000_0000_0000_B3B2_B1B0) begin
        n_err++;
        $display("FAIL part_word1: got %h %h", addr_log[1], data_log[1]);
      end
    end
    n_vec++;
    if (done_cnt !== 1 || done_cyc <= cmp_cyc) begin
      n_err++;
      $display("FAIL part_done: got %0d pulses at %0d (last complete %0d)", done_cnt, done_cyc, cmp_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_word;
    clear_logs();
    hold = 1'b1;
    pulse_start(32'h0000_1000, 24'd128);
    feed(128, 8'h00, 200);
    n_vec++;
    if (pix_sent !== 79 || pix_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall: got %0d accepted ready %b want 79 ready 0", pix_sent, pix_ready);
    end
    n_vec++;
    if (addr_log.size() !== 1) begin
      n_err++;
      $display("FAIL bp_held: got %0d writes want 1", addr_log.size());
    end
    hold = 1'b0;
    feed(128, 8'h00, 2000);
    wait_done(500);
    n_vec++;
    if (addr_log.size() !== 8) begin
      n_err++;
      $display("FAIL bp_count: got %0d writes want 8", addr_log.size());
    end else begin
      for (int w = 0; w < 8; w++) begin
        for (int k = 0; k < 16; k++) exp_word[8*k +: 8] = 8'(16 * w + k);
        n_vec++;
        if (addr_log[w] !== 32'h1000 + 32'(16 * w) || data_log[w] !== exp_word) begin
          n_err++;
          $display("FAIL bp_word%0d: got %h %h want %h %h", w, addr_log[w], data_log[w],
                   32'h1000 + 32'(16 * w), exp_word);
        end
      end
    end
    n_vec++;
    if (dup_cnt !== 0 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL bp_dup_done: got dup %0d done %0d want 0 1", dup_cnt, done_cnt);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    clear_logs();
    pulse_start(32'h0000_3000, 24'd0);
    n_vec++;
    if (frame_done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL zero_c1: got done %b busy %b want 0 1", frame_done, busy);
    end
    tick();
    n_vec++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL zero_c2: got done %b want 1", frame_done);
    end
    tick();
    n_vec++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || addr_log.size() !== 0) begin
      n_err++;
      $display("FAIL zero_c3: got done %b busy %b writes %0d want 0 0 0",
               frame_done, busy, addr_log.size());
    end
    clear_logs();
    pulse_start(32'h0000_2000, 24'd32);
    pulse_start(32'h0000_9000, 24'd16);
    feed(32, 8'h40, 200);
    wait_done(200);
    n_vec++;
    if (addr_log.size() !== 2) begin
      n_err++;
      $display("FAIL ign_count: got %0d writes want 2", addr_log.size());
    end else begin
      n_vec++;
      if (addr_log[0] !== 32'h2000 || addr_log[1] !== 32'h2010 ||
          data_log[0] !== 128'h4F4E4D4C4B4A49484746454443424140) begin
        n_err++;
        $display("FAIL ign_words: got %h %h %h", addr_log[0], addr_log[1], data_log[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    hold = 1'b1;
    pulse_start(32'h0000_1000, 24'd48);
    feed(48, 8'h00, 200);
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (addr_log.size() !== 1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: got %0d writes busy %b want 1 1", addr_log.size(), busy);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if ({pix_ready, wr_en, busy, frame_done} !== 4'b0000 || sdram_address !== 32'h0 ||
        write_data_input !== 128'h0) begin
      n_err++;
      $display("FAIL rst_outputs: got flags %b addr %h data %h want 0",
               {pix_ready, wr_en, busy, frame_done}, sdram_address, write_data_input);
    end
    reset = 1'b0;
    hold  = 1'b0;
    tick();
    clear_logs();
    pulse_start(32'h0000_4000, 24'd16);
    feed(16, 8'h50, 200);
    wait_done(200);
    n_vec++;
    if (addr_log.size() !== 1) begin
      n_err++;
      $display("FAIL rst_count: got %0d writes want 1", addr_log.size());
    end else begin
      n_vec++;
      if (addr_log[0] !== 32'h4000 || data_log[0] !== 128'h5F5E5D5C5B5A59585756555453525150) begin
        n_err++;
        $display("FAIL rst_word: got %h %h", addr_log[0], data_log[0]);
      end
    end
    n_vec++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL rst_done: got %0d pulses want 1", done_cnt);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    frame_base   = 32'h0;
    frame_pixels = 24'h0;
    pix_valid    = 1'b0;
    pix_data     = 8'h0;
    test_reset();
    test_full_frame();
    test_partial();
    test_backpressure();
    test_zero_and_ignored_start();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
